kijelzo_utemezo: RTL and testbench
==================================

# kijelzo_utemezo

Display scheduler that shares the 4-digit seven-segment display driver between two requesters: the calculator result path (A, low priority) and the error/status path (B, high priority, optional blinking). It arbitrates with a req/ack handshake, latches the winning 16-bit BCD word, enforces a minimum on-screen hold time for B, and drives the driver's `din0..din3` inputs. It sits between the calculator core and the display driver.

## Interface

- `HOLD_CYCLES`, 16_000_000, minimum cycles a B message stays shown before A may replace it (1 s at 16 MHz); ≥2
- `BLINK_HALF`, 4_000_000, half-period of B blinking in cycles; ≥1
- `CW`, 24, width of hold and blink counters; must hold `HOLD_CYCLES-1` and `BLINK_HALF-1`

- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `clr`  in  1  synchronous clear: blank display, return to IDLE
- `a_req`  in  1  requester A wants to show `a_data`
- `a_data`  in  16  A digits, [3:0]=digit0 … [15:12]=digit3
- `a_ack`  out  1  one-cycle pulse: A request accepted
- `b_req`  in  1  requester B wants to show `b_data`
- `b_data`  in  16  B digits, same packing
- `b_blink`  in  1  B message blinks; sampled with `b_data`
- `b_ack`  out  1  one-cycle pulse: B request accepted
- `din0`..`din3`  out  4 each  digit codes to display driver
- `owner`  out  2  00 idle, 01 A, 10 B
- `busy`  out  1  state ≠ IDLE

## Operation

- States: IDLE, SHOW_A, SHOW_B. All outputs registered.
- Reset (async, `rst_n`=0): IDLE; `din0..din3`=4'hF (blank code); `a_ack`=`b_ack`=0; `owner`=00; `busy`=0; hold counter, blink counter, blink phase, latched blink flag = 0.
- Acceptance of X: on the edge where X is accepted, X data (and for B, `b_blink`) latched into display register, state → SHOW_X, hold counter, blink counter and phase cleared. `X_ack`=1 for exactly the following cycle.
- X is never accepted while `X_ack`=1 (a req held high re-requests at most every other cycle).
- Requester holds `X_req` and data stable until `X_ack`; may drop `req` after seeing ack.
- Accept rules per cycle (evaluated in order):
  - `clr`=1: → IDLE, blank, no ack, counters cleared; any req that cycle ignored.
  - IDLE or SHOW_A: `b_req` → accept B; else `a_req` → accept A (refresh).
  - SHOW_B: `b_req` → accept B (refresh); else `a_req` and hold expired → accept A; else nothing.
- Simultaneous `a_req`+`b_req`: B wins; A not acked, stays pending.
- Hold counter: cleared on accept, +1 per cycle, saturates at `HOLD_CYCLES-1`; expired = counter == `HOLD_CYCLES-1`. Only gates A in SHOW_B.
- No request: current state and content held indefinitely (no timeout to IDLE).
- Blink (SHOW_B with latched blink=1 only): blink counter counts 0..`BLINK_HALF-1` and wraps, toggling phase at wrap. Phase 1 → all `din`=4'hF; phase 0 → latched data. Blink=0 or SHOW_A: data shown steadily.
- `owner`/`busy` track state registered on the same edge.

## Timing

- Accept edge T: `din*`, `owner`, `busy` change at T; `X_ack` high in cycle T→T+1, low after.
- Accept-to-display latency 1 cycle; driver adds up to one scan period.
- B preempts A with no wait; A waits ≥`HOLD_CYCLES-1` cycles after last B accept.
- First blink-off phase begins `BLINK_HALF` cycles after B accept.
- `rst_n` assertion mid-hold/mid-blink: immediate blank, no pending ack survives; first accept possible on first edge after deassertion.

## Test plan

Benches use `HOLD_CYCLES`=8, `BLINK_HALF`=3.
- Reset then `a_req`=1, `a_data`=16'h1234 → next edge `din3..din0`=1,2,3,4, `owner`=01, `a_ack` one-cycle pulse; `a_req` held high → re-acked every 2nd cycle.
- SHOW_A, `b_req`=1, `b_data`=16'hE000, `b_blink`=0 → B shown next edge, `owner`=10; `a_req` asserted 1 cycle later → no `a_ack` until 7 cycles after B accept, then A shown.
- Same-cycle `a_req`+`b_req` from IDLE → only `b_ack`, B shown; A acked after hold expires.
- B accept with `b_blink`=1, `b_data`=16'h0E0E → data 3 cycles, all 4'hF 3 cycles, repeating; refresh via `b_req` restarts phase 0.
- `clr`=1 coincident with `b_req` → IDLE, `din*`=4'hF, `busy`=0, no ack.
- `rst_n` low mid-blink → outputs at reset values asynchronously, before next clock edge.

Source files
------------

// File: rtl/kijelzo_utemezo_if.sv
// rtl/kijelzo_utemezo_if.sv - requester and display-driver signal bundle for kijelzo_utemezo
//
// Purpose: carries both requester handshakes (A low priority, B high priority)
// and the display-side outputs between the calculator core, the scheduler and
// the seven-segment driver.
// Modports:
//   master - requester/driver side: drives clr, a_*/b_* requests and data,
//            observes acks and the display outputs
//   slave  - scheduler side (kijelzo_utemezo)
// Signals:
//   clr             synchronous clear
//   a_req/a_data    requester A request, 16-bit BCD word ([3:0]=digit0)
//   a_ack           one-cycle accept pulse for A
//   b_req/b_data    requester B request, same packing
//   b_blink         B message blinks, sampled together with b_data
//   b_ack           one-cycle accept pulse for B
//   din0..din3      digit codes to the display driver
//   owner           00 idle, 01 A, 10 B
//   busy            scheduler not idle
interface kijelzo_utemezo_if;
    logic        clr;
    logic        a_req;
    logic [15:0] a_data;
    logic        a_ack;
    logic        b_req;
    logic [15:0] b_data;
    logic        b_blink;
    logic        b_ack;
    logic [3:0]  din0;
    logic [3:0]  din1;
    logic [3:0]  din2;
    logic [3:0]  din3;
    logic [1:0]  owner;
    logic        busy;

    modport master (
        output clr, a_req, a_data, b_req, b_data, b_blink,
        input  a_ack, b_ack, din0, din1, din2, din3, owner, busy
    );

    modport slave (
        input  clr, a_req, a_data, b_req, b_data, b_blink,
        output a_ack, b_ack, din0, din1, din2, din3, owner, busy
    );
endinterface

// File: rtl/kijelzo_utemezo.sv
// rtl/kijelzo_utemezo.sv - two-requester scheduler for the 4-digit seven-segment display
//
// Purpose: arbitrates the calculator result path (A) and the error/status path
// (B, higher priority, optional blinking) onto the display driver inputs.
// B preempts immediately; A may replace B only after B has been on screen for
// the minimum hold time. All outputs are registered.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     kijelzo_utemezo_if.slave: clr, a_/b_ handshakes, din0..din3, owner, busy
// Parameters:
//   HOLD_CYCLES  minimum B on-screen cycles before A may replace it (>=2)
//   BLINK_HALF   half-period of B blinking in cycles (>=1)
//   CW           width of hold and blink counters
module kijelzo_utemezo #(
    parameter int HOLD_CYCLES = 16_000_000,
    parameter int BLINK_HALF  = 4_000_000,
    parameter int CW          = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kijelzo_utemezo_if.slave     bus
);

    // State codes double as the owner encoding.
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_SHOW_A = 2'b01;
    localparam logic [1:0] S_SHOW_B = 2'b10;

    localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_MAX = CW'(BLINK_HALF - 1);
    localparam logic [15:0]   BLANK     = 16'hFFFF;

    logic [1:0]    state_q,  state_d;
    logic [15:0]   data_q,   data_d;
    logic          flag_q,   flag_d;
    logic [CW-1:0] hold_q,   hold_d;
    logic [CW-1:0] bcnt_q,   bcnt_d;
    logic          phase_q,  phase_d;
    logic          a_ack_q,  a_ack_d;
    logic          b_ack_q,  b_ack_d;
    logic [15:0]   din_q,    din_d;
    logic          busy_q;

    logic b_ok;
    logic a_ok;
    logic hold_exp;

    // A requester whose ack is still high is not re-accepted, so a held req
    // is served at most every other cycle.
    assign b_ok     = bus.b_req && !b_ack_q;
    assign a_ok     = bus.a_req && !a_ack_q;
    assign hold_exp = (hold_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        flag_d  = flag_q;
        hold_d  = hold_exp ? hold_q : hold_q + CW'(1);
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;

        if (state_q == S_SHOW_B && flag_q) begin
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + CW'(1);
            end
        end

        if (bus.clr) begin
            state_d = S_IDLE;
            data_d  = BLANK;
            flag_d  = 1'b0;
            hold_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (b_ok) begin
            state_d = S_SHOW_B;
            data_d  = bus.b_data;
            flag_d  = bus.b_blink;
            hold_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
            b_ack_d = 1'b1;
        end else if (a_ok && (state_q != S_SHOW_B || hold_exp)) begin
            state_d = S_SHOW_A;
            data_d  = bus.a_data;
            flag_d  = 1'b0;
            hold_d  = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
            a_ack_d = 1'b1;
        end

        // Display content is derived from the next state so it changes on
        // the same edge as the accept or blink-phase toggle.
        if (state_d == S_IDLE || (state_d == S_SHOW_B && flag_d && phase_d)) begin
            din_d = BLANK;
        end else begin
            din_d = data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= BLANK;
            flag_q  <= 1'b0;
            hold_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            din_q   <= BLANK;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            hold_q  <= hold_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            din_q   <= din_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign bus.a_ack = a_ack_q;
    assign bus.b_ack = b_ack_q;
    assign bus.din0  = din_q[3:0];
    assign bus.din1  = din_q[7:4];
    assign bus.din2  = din_q[11:8];
    assign bus.din3  = din_q[15:12];
    assign bus.owner = state_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_kijelzo_utemezo.sv
// tb/tb_kijelzo_utemezo.sv - directed self-checking bench for kijelzo_utemezo
module tb_kijelzo_utemezo;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    kijelzo_utemezo_if bus_if ();

    kijelzo_utemezo #(
        .HOLD_CYCLES (8),
        .BLINK_HALF  (3),
        .CW          (24)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; returns on the following falling edge so outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] disp();
        return {bus_if.din3, bus_if.din2, bus_if.din1, bus_if.din0};
    endfunction

    logic [15:0] blink_exp [9];
    int          seen_at;
    int          ack_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus_if.clr     = 1'b0;
        bus_if.a_req   = 1'b0;
        bus_if.a_data  = 16'h0000;
        bus_if.b_req   = 1'b0;
        bus_if.b_data  = 16'h0000;
        bus_if.b_blink = 1'b0;
        tick();
        tick();
        check("rst_din",   32'(disp()),        32'h0000FFFF);
        check("rst_owner", 32'(bus_if.owner),  32'd0);
        check("rst_busy",  32'(bus_if.busy),   32'd0);
        check("rst_acks",  32'({bus_if.a_ack, bus_if.b_ack}), 32'd0);
        rst_n = 1'b1;

        // A accepted, held req re-acked every other cycle
        bus_if.a_req  = 1'b1;
        bus_if.a_data = 16'h1234;
        tick();
        check("a1_din",   32'(disp()),       32'h00001234);
        check("a1_owner", 32'(bus_if.owner), 32'd1);
        check("a1_busy",  32'(bus_if.busy),  32'd1);
        check("a1_ack",   32'(bus_if.a_ack), 32'd1);
        tick();
        check("a1_ack_gap", 32'(bus_if.a_ack), 32'd0);
        tick();
        check("a1_reack",   32'(bus_if.a_ack), 32'd1);
        bus_if.a_req = 1'b0;
        tick();
        check("a1_ack_end", 32'(bus_if.a_ack), 32'd0);

        // B preempts A; A blocked until hold expires
        bus_if.b_req   = 1'b1;
        bus_if.b_data  = 16'hE000;
        bus_if.b_blink = 1'b0;
        tick();
        check("b1_ack",   32'(bus_if.b_ack), 32'd1);
        check("b1_owner", 32'(bus_if.owner), 32'd2);
        check("b1_din",   32'(disp()),       32'h0000E000);
        bus_if.b_req  = 1'b0;
        bus_if.a_req  = 1'b1;
        bus_if.a_data = 16'h5678;
        ack_cnt = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (bus_if.a_ack) ack_cnt++;
        end
        check("hold_no_ack", 32'(ack_cnt),      32'd0);
        check("hold_owner",  32'(bus_if.owner), 32'd2);
        check("hold_din",    32'(disp()),       32'h0000E000);
        tick();
        check("a2_ack",   32'(bus_if.a_ack), 32'd1);
        check("a2_din",   32'(disp()),       32'h00005678);
        check("a2_owner", 32'(bus_if.owner), 32'd1);
        bus_if.a_req = 1'b0;
        tick();

        // Simultaneous requests from IDLE
        bus_if.clr = 1'b1;
        tick();
        check("clr_busy", 32'(bus_if.busy), 32'd0);
        check("clr_din",  32'(disp()),      32'h0000FFFF);
        bus_if.clr    = 1'b0;
        bus_if.a_req  = 1'b1;
        bus_if.a_data = 16'h1111;
        bus_if.b_req  = 1'b1;
        bus_if.b_data = 16'h2222;
        tick();
        check("both_acks", 32'({bus_if.a_ack, bus_if.b_ack}), 32'b01);
        check("both_din",  32'(disp()), 32'h00002222);
        bus_if.b_req = 1'b0;
        seen_at = 0;
        for (int k = 1; k <= 20 && seen_at == 0; k++) begin
            tick();
            if (bus_if.a_ack) seen_at = k;
        end
        check("both_a_after_hold", 32'(seen_at), 32'd8);
        check("both_a_din",        32'(disp()),  32'h00001111);
        bus_if.a_req = 1'b0;
        tick();

        // Blinking B: 3 cycles data, 3 cycles blank
        blink_exp = '{16'h0E0E, 16'h0E0E, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                      16'h0E0E, 16'h0E0E, 16'h0E0E, 16'hFFFF};
        bus_if.b_req   = 1'b1;
        bus_if.b_data  = 16'h0E0E;
        bus_if.b_blink = 1'b1;
        tick();
        check("blink_acc", 32'(disp()), 32'h00000E0E);
        bus_if.b_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("blink_k%0d", k + 1), 32'(disp()), 32'(blink_exp[k]));
        end
        bus_if.b_req = 1'b1;
        tick();
        check("refresh_acc", 32'(disp()), 32'h00000E0E);
        bus_if.b_req = 1'b0;
        tick();
        tick();
        check("refresh_k2", 32'(disp()), 32'h00000E0E);
        tick();
        check("refresh_k3", 32'(disp()), 32'h0000FFFF);

        // clr wins over a coincident b_req
        bus_if.b_req = 1'b1;
        bus_if.clr   = 1'b1;
        tick();
        check("clrb_busy",  32'(bus_if.busy),  32'd0);
        check("clrb_owner", 32'(bus_if.owner), 32'd0);
        check("clrb_din",   32'(disp()),       32'h0000FFFF);
        check("clrb_ack",   32'(bus_if.b_ack), 32'd0);
        bus_if.b_req = 1'b0;
        bus_if.clr   = 1'b0;
        tick();

        // Asynchronous reset mid-blink, between edges
        bus_if.b_req   = 1'b1;
        bus_if.b_data  = 16'h0E0E;
        bus_if.b_blink = 1'b1;
        tick();
        bus_if.b_req = 1'b0;
        check("arst_pre_ack", 32'(bus_if.b_ack), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_din",   32'(disp()),        32'h0000FFFF);
        check("arst_owner", 32'(bus_if.owner),  32'd0);
        check("arst_busy",  32'(bus_if.busy),   32'd0);
        check("arst_ack",   32'(bus_if.b_ack),  32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus_if.a_req  = 1'b1;
        bus_if.a_data = 16'h4321;
        tick();
        check("post_rst_ack", 32'(bus_if.a_ack), 32'd1);
        check("post_rst_din", 32'(disp()),       32'h00004321);
        bus_if.a_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
